// File: rtl/fetch_ifid_pkg.sv
// Shared fetch-stage types and constants
// for the IF stage and IF/ID register.
package fetch_ifid_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } fetch_state_e;

  typedef enum logic [1:0] {
    SRC_BTGT,
    SRC_JUMP,
    SRC_JR
  } tgt_src_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;

  // jr outranks j/jal, which outranks a branch
  function automatic tgt_src_e tgt_src(
    input logic jump,
    input logic jr
  );
    tgt_src_e s;
    if (jr)
      s = SRC_JR;
    else if (jump)
      s = SRC_JUMP;
    else
      s = SRC_BTGT;
    return s;
  endfunction

endpackage

// File: rtl/fetch_target_sel.sv
// Redirect target mux (jr / j / branch)
// with forced word alignment.
module fetch_target_sel
  import fetch_ifid_pkg::*;
(
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] btgt,
  input  logic [31:0] ra,
  input  logic [3:0]  pc_hi,
  input  logic [25:0] index,
  output logic [31:0] target
);

  tgt_src_e    src;
  logic [31:0] raw;

  assign src = tgt_src(jump, jr);

  // select the raw target by priority source
  always_comb begin
    raw = btgt;
    unique case (src)
      SRC_JR:   raw = ra;
      SRC_JUMP: raw = {pc_hi, index, 2'b00};
      default:  raw = btgt;
    endcase
  end

  assign target = raw & WORD_MASK;

endmodule

// File: rtl/fetch_ifid.sv
// Instruction fetch stage with single-outstanding
// imem port and IF/ID pipeline register.
module fetch_ifid
  import fetch_ifid_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        WPCIR,
  input  logic        BRANCH,
  input  logic        JUMP,
  input  logic        JR,
  input  logic [31:0] ID_BTGT,
  input  logic [31:0] ID_RA,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IDIR,
  output logic [31:0] IDPC4,
  output logic        IDVALID
);

  fetch_state_e state, state_n;
  logic [31:0]  fpc, fpc_n, fpc_inc;
  logic [31:0]  rpc, rpc_n;
  logic         squash, squash_n;
  logic [31:0]  hold_ir, hold_ir_n;
  logic [31:0]  hold_pc4, hold_pc4_n;
  logic [31:0]  ir_n, pc4_n;
  logic         vld_n;
  logic         redirect;
  logic [31:0]  target;

  fetch_target_sel u_tgt (
    .jump  (JUMP),
    .jr    (JR),
    .btgt  (ID_BTGT),
    .ra    (ID_RA),
    .pc_hi (IDPC4[31:28]),
    .index (IDIR[25:0]),
    .target(target)
  );

  assign redirect  = BRANCH & ~WPCIR & IDVALID;
  assign IMEM_REQ  = (state == S_REQ);
  assign IMEM_ADDR = fpc & WORD_MASK;
  assign fpc_inc   = IMEM_ADDR + 32'd4;

  // next-state: fetch control, squash and IF/ID load
  always_comb begin
    state_n    = state;
    fpc_n      = fpc;
    rpc_n      = rpc;
    squash_n   = squash;
    hold_ir_n  = hold_ir;
    hold_pc4_n = hold_pc4;
    ir_n       = IDIR;
    pc4_n      = IDPC4;
    vld_n      = IDVALID;
    unique case (state)
      S_IDLE: state_n = S_REQ;
      S_REQ: begin
        if (!WPCIR) begin
          ir_n  = NOP_INSTR;
          vld_n = 1'b0;
        end
        if (IMEM_ACK && squash) begin
          squash_n = 1'b0;
          fpc_n    = rpc;
        end else if (IMEM_ACK && !redirect) begin
          fpc_n = fpc_inc;
          if (WPCIR) begin
            hold_ir_n  = IMEM_RDATA;
            hold_pc4_n = fpc_inc;
            state_n    = S_HOLD;
          end else begin
            ir_n  = IMEM_RDATA;
            pc4_n = fpc_inc;
            vld_n = 1'b1;
          end
        end
        if (redirect && IMEM_ACK) begin
          fpc_n = target;
        end else if (redirect) begin
          squash_n = 1'b1;
          rpc_n    = target;
        end
      end
      S_HOLD: begin
        if (!WPCIR) begin
          state_n = S_REQ;
          if (redirect) begin
            ir_n  = NOP_INSTR;
            vld_n = 1'b0;
            fpc_n = target;
          end else begin
            ir_n  = hold_ir;
            pc4_n = hold_pc4;
            vld_n = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // state and pipeline registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= S_IDLE;
      fpc      <= RESET_PC;
      rpc      <= RESET_PC;
      squash   <= 1'b0;
      hold_ir  <= NOP_INSTR;
      hold_pc4 <= '0;
      IDIR     <= NOP_INSTR;
      IDPC4    <= '0;
      IDVALID  <= 1'b0;
    end else begin
      state    <= state_n;
      fpc      <= fpc_n;
      rpc      <= rpc_n;
      squash   <= squash_n;
      hold_ir  <= hold_ir_n;
      hold_pc4 <= hold_pc4_n;
      IDIR     <= ir_n;
      IDPC4    <= pc4_n;
      IDVALID  <= vld_n;
    end
  end

endmodule

// File: tb/tb_fetch_ifid.sv
// Bench for fetch_ifid: directed cycle table
// plus random run against a program-order model.
module tb_fetch_ifid;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        WPCIR = 1'b0;
  logic        BRANCH = 1'b0;
  logic        JUMP = 1'b0;
  logic        JR = 1'b0;
  logic [31:0] ID_BTGT = '0;
  logic [31:0] ID_RA = '0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic [31:0] IDIR;
  logic [31:0] IDPC4;
  logic        IDVALID;

  fetch_ifid dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .WPCIR     (WPCIR),
    .BRANCH    (BRANCH),
    .JUMP      (JUMP),
    .JR        (JR),
    .ID_BTGT   (ID_BTGT),
    .ID_RA     (ID_RA),
    .IMEM_REQ  (IMEM_REQ),
    .IMEM_ADDR (IMEM_ADDR),
    .IMEM_ACK  (IMEM_ACK),
    .IMEM_RDATA(IMEM_RDATA),
    .IDIR      (IDIR),
    .IDPC4     (IDPC4),
    .IDVALID   (IDVALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rs;
    logic        wp;
    logic        br;
    logic        jp;
    logic        jr;
    logic [31:0] bt;
    logic [31:0] ra;
    logic        ak;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_ir;
    logic [31:0] e_pc4;
    logic        e_vld;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] JW  = 32'h0800_0040;
  localparam logic [31:0] XX  = 32'hDEAD_BEEF;

  function automatic logic [31:0] w(input int n);
    return 32'hC0DE_0000 | 32'(n);
  endfunction

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] model_tgt(
    input logic jr, input logic jp,
    input logic [31:0] bt, input logic [31:0] ra,
    input logic [31:0] pc4, input logic [31:0] ir
  );
    logic [31:0] t;
    if (jr)      t = ra;
    else if (jp) t = {pc4[31:28], ir[25:0], 2'b00};
    else         t = bt;
    return {t[31:2], 2'b00};
  endfunction

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(
    input logic rs, input logic wp, input logic br,
    input logic jp, input logic jr,
    input logic [31:0] bt, input logic [31:0] ra,
    input logic ak, input logic [31:0] rd,
    input logic rq, input logic [31:0] ad,
    input logic [31:0] ir, input logic [31:0] p4,
    input logic vl
  );
    vec_t v;
    v.rs = rs; v.wp = wp; v.br = br;
    v.jp = jp; v.jr = jr;
    v.bt = bt; v.ra = ra;
    v.ak = ak; v.rd = rd;
    v.e_req = rq; v.e_addr = ad;
    v.e_ir = ir; v.e_pc4 = p4; v.e_vld = vl;
    vecs.push_back(v);
  endtask

  logic [31:0] exp_pc;
  logic        pr_req;
  logic        pr_ack;
  logic [31:0] pr_addr;
  int          n_ret;

  initial begin
    // rs wp br jp jr bt ra ak rd | req addr ir pc4 vld
    add(1,0,0,0,0, 0,0, 0,XX, 0,32'h0,NOP,32'h0,0);
    add(1,0,0,0,0, 0,0, 1,w(0), 1,32'h0,NOP,32'h0,0);
    add(1,0,0,0,0, 0,0, 1,w(1), 1,32'h4,w(0),32'h4,1);
    add(1,0,0,0,0, 0,0, 1,w(2), 1,32'h8,w(1),32'h8,1);
    add(1,1,0,0,0, 0,0, 1,w(3), 1,32'hC,w(2),32'hC,1);
    add(1,1,0,0,0, 0,0, 0,XX, 0,32'h10,w(2),32'hC,1);
    add(1,0,0,0,0, 0,0, 0,XX, 0,32'h10,w(2),32'hC,1);
    add(1,0,1,0,0, 32'h40,0, 1,w(4),
        1,32'h10,w(3),32'h10,1);
    add(1,0,0,0,0, 0,0, 1,w(5), 1,32'h40,NOP,32'h10,0);
    add(1,0,1,1,1, 0,32'h103, 0,XX,
        1,32'h44,w(5),32'h44,1);
    add(1,0,0,0,0, 0,0, 0,XX, 1,32'h44,NOP,32'h44,0);
    add(1,0,0,0,0, 0,0, 0,XX, 1,32'h44,NOP,32'h44,0);
    add(1,0,0,0,0, 0,0, 1,w(6), 1,32'h44,NOP,32'h44,0);
    add(1,0,0,0,0, 0,0, 1,JW, 1,32'h100,NOP,32'h44,0);
    add(1,0,1,0,1, 0,32'h3000_000C, 1,w(7),
        1,32'h104,JW,32'h104,1);
    add(1,0,0,0,0, 0,0, 1,JW,
        1,32'h3000_000C,NOP,32'h104,0);
    add(1,0,1,1,0, 0,0, 1,w(8),
        1,32'h3000_0010,JW,32'h3000_0010,1);
    add(1,0,1,0,0, 32'hFFFF_FFFC,0, 1,w(9),
        1,32'h3000_0100,NOP,32'h3000_0010,0);
    add(1,1,1,0,0, 32'hFFFF_FFFC,0, 0,XX,
        1,32'h3000_0104,w(9),32'h3000_0104,1);
    add(1,0,1,0,0, 32'hFFFF_FFFD,0, 1,w(10),
        1,32'h3000_0104,w(9),32'h3000_0104,1);
    add(1,0,0,0,0, 0,0, 1,w(11),
        1,32'hFFFF_FFFC,NOP,32'h3000_0104,0);
    add(1,0,0,0,0, 0,0, 0,XX, 1,32'h0,w(11),32'h0,1);
    add(1,0,0,0,0, 0,0, 0,XX, 1,32'h0,NOP,32'h0,0);
    add(1,0,0,0,0, 0,0, 1,w(12), 1,32'h0,NOP,32'h0,0);
    add(1,0,1,0,0, 32'hFFFF_FFFC,0, 1,w(13),
        1,32'h4,w(12),32'h4,1);
    add(1,0,0,0,0, 0,0, 0,XX,
        1,32'hFFFF_FFFC,NOP,32'h4,0);
    add(0,0,0,0,0, 0,0, 0,XX, 0,32'h0,NOP,32'h0,0);
    add(1,0,0,0,0, 0,0, 1,w(14), 0,32'h0,NOP,32'h0,0);
    add(1,0,0,0,0, 0,0, 1,w(15), 1,32'h0,NOP,32'h0,0);
    add(1,0,0,0,0, 0,0, 0,XX, 1,32'h4,w(15),32'h4,1);

    repeat (3) @(negedge CLK);
    foreach (vecs[i]) begin
      @(negedge CLK);
      RSTN       = vecs[i].rs;
      WPCIR      = vecs[i].wp;
      BRANCH     = vecs[i].br;
      JUMP       = vecs[i].jp;
      JR         = vecs[i].jr;
      ID_BTGT    = vecs[i].bt;
      ID_RA      = vecs[i].ra;
      IMEM_ACK   = vecs[i].ak;
      IMEM_RDATA = vecs[i].rd;
      #1;
      chk($sformatf("r%0d req", i),
          32'(IMEM_REQ), 32'(vecs[i].e_req));
      chk($sformatf("r%0d addr", i),
          IMEM_ADDR, vecs[i].e_addr);
      chk($sformatf("r%0d idir", i),
          IDIR, vecs[i].e_ir);
      chk($sformatf("r%0d idpc4", i),
          IDPC4, vecs[i].e_pc4);
      chk($sformatf("r%0d idvalid", i),
          32'(IDVALID), 32'(vecs[i].e_vld));
    end

    @(negedge CLK);
    RSTN = 1'b0;
    WPCIR = 1'b0; BRANCH = 1'b0;
    JUMP = 1'b0; JR = 1'b0;
    IMEM_ACK = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;

    exp_pc  = 32'h0;
    pr_req  = 1'b0;
    pr_ack  = 1'b0;
    pr_addr = '0;
    n_ret   = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      WPCIR   = ($urandom_range(3) == 0);
      BRANCH  = ($urandom_range(6) == 0);
      JUMP    = 1'($urandom_range(1));
      JR      = ($urandom_range(3) == 0);
      ID_BTGT = $urandom;
      ID_RA   = $urandom;
      IMEM_ACK = IMEM_REQ && ($urandom_range(2) != 0);
      IMEM_RDATA = IMEM_REQ ? mem(IMEM_ADDR) : $urandom;
      #1;
      if (pr_req && !pr_ack) begin
        chk("rnd req held", 32'(IMEM_REQ), 32'h1);
        chk("rnd addr stable", IMEM_ADDR, pr_addr);
      end
      if (IDVALID && !WPCIR) begin
        chk("rnd idir", IDIR, mem(exp_pc));
        chk("rnd idpc4", IDPC4, exp_pc + 32'd4);
        n_ret++;
        if (BRANCH)
          exp_pc = model_tgt(JR, JUMP, ID_BTGT, ID_RA,
                             exp_pc + 32'd4, mem(exp_pc));
        else
          exp_pc = exp_pc + 32'd4;
      end
      pr_req  = IMEM_REQ;
      pr_ack  = IMEM_ACK;
      pr_addr = IMEM_ADDR;
    end
    chk("rnd progress", 32'(n_ret >= 300), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ifid.md
Name: fetch_ifid

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the ID-stage controller.
- Fetches over a single-outstanding req/ack instruction-memory port and presents IDIR/IDPC4 to ID.
- Consumes the controller's WPCIR (stall), BRANCH, JUMP and JR outputs to hold, redirect and squash fetch.
- No branch delay slot: every taken redirect squashes the sequential instruction behind it.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0000, bubble word driven on IDIR (sll $0,$0,0).

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RSTN  in  1  reset; asynchronous, active-low.
- WPCIR  in  1  ID stall from controller; 1 = hold PC and IF/ID.
- BRANCH  in  1  taken redirect (branch, jump or jr) from controller.
- JUMP  in  1  redirect is j/jal.
- JR  in  1  redirect is jr.
- ID_BTGT  in  32  branch target computed in ID.
- ID_RA  in  32  forwarded rs value, used as the jr target.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  32  fetch address, word-aligned.
- IMEM_ACK  in  1  read data valid; completes the request.
- IMEM_RDATA  in  32  instruction word.
- IDIR  out  32  IF/ID instruction.
- IDPC4  out  32  IF/ID PC+4 of IDIR; ID uses it for branch targets and jal.
- IDVALID  out  1  IDIR holds a real instruction, not a bubble.

Behaviour:
- Reset (RSTN=0, asynchronous):
  - IDIR=NOP_INSTR, IDPC4=0, IDVALID=0, IMEM_REQ=0.
  - FPC=RESET_PC, SQUASH=0, HOLDBUF empty, state S_IDLE.
- Reset mid-request: any in-flight ACK arriving after RSTN rises while in S_IDLE is ignored.
- States: S_IDLE, S_REQ, S_HOLD.
- S_IDLE: exactly one cycle after RSTN deasserts; then IMEM_REQ=1, IMEM_ADDR=FPC, go S_REQ.
- S_REQ:
  - IMEM_REQ=1.
  - IMEM_ADDR={FPC[31:2],2'b00}, held stable until ACK.
  - Back-to-back requests are allowed, so a zero-wait memory gives one instruction per cycle.
- ACK with SQUASH=1: data dropped; SQUASH cleared; FPC<=RPC; stay S_REQ.
- ACK with SQUASH=0 and WPCIR=0:
  - IDIR<=RDATA, IDPC4<=FPC+4, IDVALID<=1, FPC<=FPC+4.
- ACK with SQUASH=0 and WPCIR=1:
  - RDATA and FPC+4 captured in HOLDBUF; IF/ID unchanged.
  - FPC<=FPC+4; IMEM_REQ=0 next cycle; go S_HOLD.
- No ACK: if WPCIR=0, IF/ID loads a bubble (IDIR=NOP_INSTR, IDVALID=0); if WPCIR=1, IF/ID holds.
- S_HOLD: IMEM_REQ=0. When WPCIR=0, IF/ID<=HOLDBUF, IDVALID=1, go S_REQ next cycle.
- Redirect is taken when BRANCH=1 && WPCIR=0 && IDVALID=1:
  - Target priority: JR -> ID_RA; else JUMP -> {IDPC4[31:28],IDIR[25:0],2'b00}; else ID_BTGT.
  - IF/ID loads a bubble; any same-cycle ACK data or HOLDBUF contents are discarded.
  - If a request is pending with no ACK that cycle: SQUASH<=1, RPC<=target.
  - Otherwise: FPC<=target, state S_REQ.
- BRANCH while WPCIR=1 is ignored; the controller re-asserts it once the stall clears.
- Arithmetic:
  - All PC math is modulo 2^32: 32'hFFFF_FFFC+4 = 0.
  - Target bits [1:0] are forced to 0.
- Second redirect while SQUASH=1: RPC is overwritten and SQUASH stays 1.

Decomposition:
- Shared pipeline package:
  - state enum {S_IDLE,S_REQ,S_HOLD};
  - NOP_INSTR and RESET_PC defaults;
  - constants for redirect-source priority.
- One sub-module, fetch_target_sel: combinational JR/JUMP/BRANCH target mux plus word alignment; also reused by the ID-stage target checker.

Test Plan:
- Reset release, ACK always high:
  - IMEM_ADDR 0x0,0x4,0x8 on consecutive cycles.
  - IDPC4 0x4,0x8,0xC, one cycle after each fetch.
  - IDVALID=1 from cycle 3.
- WPCIR=1 for 2 cycles with ACK in the first:
  - IDIR held.
  - HOLDBUF word appears on IDIR the cycle WPCIR falls.
  - IMEM_REQ=0 during S_HOLD.
  - No instruction lost or duplicated.
- beq taken, ID_BTGT=0x40, ACK same cycle: sequential word dropped, IDVALID=0 one cycle, next IMEM_ADDR=0x40.
- Redirect with ACK delayed 3 cycles:
  - IMEM_ADDR stays stable until ACK.
  - Returned data is discarded.
  - Next request is to the target; SQUASH clears.
- JR=1 and JUMP=1 together, ID_RA=0x100: target 0x100. j with IDPC4=0x3000_0010, index 0x40: target 0x3000_0100.
- RSTN pulsed low mid-request, FPC=0xFFFF_FFFC before reset:
  - Outputs go to reset values immediately.
  - Next fetch is at RESET_PC.
  - A wrap test without reset gives 0xFFFF_FFFC -> 0x0000_0000.
